// File: rtl/k2_unscale.sv
// Removes the k^2 = qH^2 factor left by K2-RED: out = T * 2^(2W) mod q, q = qH*2^W + 1.
// Latency 2 + 2W/STEPS cycles from accept; one value in flight; out_data held until out_ready.
module k2_unscale #(
  parameter int LOGQ  = 32,
  parameter int LOGQH = 15,
  parameter int STEPS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LOGQH-1:0] qH,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LOGQ-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOGQ-1:0]  out_data
);

  localparam int W    = LOGQ - LOGQH;
  localparam int TWOW = 2 * W;
  localparam int CW   = $clog2(TWOW + 1);

  generate
    if (STEPS < 1 || (TWOW % STEPS) != 0) begin : g_bad_steps
      $error("k2_unscale: STEPS must divide 2*W");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, PRE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [LOGQ:0]    x_q, x_d;
  logic [LOGQ-1:0]  qr_q, qr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LOGQ-1:0]  od_q, od_d;

  logic [LOGQ:0]    q_ext;
  logic [LOGQ-1:0]  q_in;
  logic [LOGQ:0]    x_run;
  logic [CW-1:0]    cnt_step;
  logic             accept;
  logic             run_last;

  assign q_ext    = {1'b0, qr_q};
  assign q_in     = {qH, {W{1'b0}}} | LOGQ'(1);
  assign accept   = in_valid && in_ready;
  assign cnt_step = cnt_q + CW'(STEPS);
  assign run_last = (cnt_step == CW'(TWOW));

  // x < q on entry, so 2x fits LOGQ+1 bits and one conditional subtract reduces it.
  always_comb begin
    x_run = x_q;
    for (int i = 0; i < STEPS; i++) begin
      x_run = {x_run[LOGQ-1:0], 1'b0};
      if (x_run >= q_ext) x_run = x_run - q_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = PRE;
      PRE:     state_d = RUN;
      RUN:     if (run_last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == DONE);
  end

  always_comb begin
    x_d   = x_q;
    qr_d  = qr_q;
    cnt_d = cnt_q;
    od_d  = od_q;
    case (state_q)
      IDLE: if (accept) begin
        x_d   = {1'b0, in_data};
        qr_d  = q_in;
        cnt_d = '0;
      end
      // Any LOGQ-bit input is below 2q, so a single subtract fully reduces it.
      PRE:  if (x_q >= q_ext) x_d = x_q - q_ext;
      RUN: begin
        x_d   = x_run;
        cnt_d = cnt_step;
        if (run_last) od_d = x_run[LOGQ-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q   <= '0;
      qr_q  <= '0;
      cnt_q <= '0;
      od_q  <= '0;
    end else begin
      x_q   <= x_d;
      qr_q  <= qr_d;
      cnt_q <= cnt_d;
      od_q  <= od_d;
    end
  end

  assign out_data = od_q;

endmodule

// File: tb/tb_k2_unscale.sv
// Bench for k2_unscale: Kyber STEPS=1, Kyber STEPS=4 and default-parameter instances.
module tb_k2_unscale;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv[3];
  logic        ir[3];
  logic        ov[3];
  logic        ordy[3];
  logic [31:0] id[3];
  logic [31:0] od[3];
  logic [14:0] qh[3];
  logic [11:0] od0, od1;
  logic [31:0] od2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign od[0] = {20'd0, od0};
  assign od[1] = {20'd0, od1};
  assign od[2] = od2;

  k2_unscale #(.LOGQ(12), .LOGQH(4), .STEPS(1)) u_k1 (
    .clk(clk), .rst(rst), .qH(qh[0][3:0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(id[0][11:0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od0));

  k2_unscale #(.LOGQ(12), .LOGQH(4), .STEPS(4)) u_k4 (
    .clk(clk), .rst(rst), .qH(qh[1][3:0]), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(id[1][11:0]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od1));

  k2_unscale u_def (
    .clk(clk), .rst(rst), .qH(qh[2]), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_data(id[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od2));

  function automatic int wof(int d);
    return (d == 2) ? 17 : 8;
  endfunction

  function automatic int lat(int d);
    return 2 + (2 * wof(d)) / ((d == 1) ? 4 : 1);
  endfunction

  function automatic logic [127:0] modq(int d, logic [14:0] h);
    logic [14:0] hm;
    hm = (d == 2) ? h : (h & 15'hF);
    return (128'(hm) << wof(d)) | 128'd1;
  endfunction

  // Reference: T * 2^(2W) mod q in wide integer arithmetic.
  function automatic logic [31:0] model(int d, logic [31:0] t, logic [14:0] h);
    logic [127:0] q, p, tm;
    q  = modq(d, h);
    tm = (d == 2) ? 128'(t) : 128'(t & 32'hFFF);
    p  = tm * (128'd1 << (2 * wof(d)));
    return 32'(p % q);
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-level model: one transaction in flight, fixed latency, data captured at accept.
  int          cyc = 0;
  logic        busy[3];
  int          acc[3];
  logic [31:0] ev[3];
  int          nres[3];

  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("in_ready[%0d]", d), 64'(ir[d]), 64'(!rst && !busy[d]));
      chk($sformatf("out_valid[%0d]", d), 64'(ov[d]), 64'(busy[d] && (cyc - acc[d] >= lat(d))));
      if (ov[d] && busy[d]) chk($sformatf("out_data[%0d]", d), 64'(od[d]), 64'(ev[d]));
      if (rst) busy[d] = 1'b0;
      else if (ov[d] && ordy[d]) begin
        busy[d] = 1'b0;
        nres[d]++;
      end else if (iv[d] && ir[d]) begin
        busy[d] = 1'b1;
        acc[d]  = cyc;
        ev[d]   = model(d, id[d], qh[d]);
      end
    end
  end

  task automatic run(int d, logic [31:0] t, longint lit, int hold);
    int          n;
    bit          got;
    logic [31:0] first;
    logic [127:0] q, lhs;
    @(posedge clk); #1;
    id[d] = t;
    iv[d] = 1'b1;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (ir[d]) got = 1;
    end
    @(posedge clk); #1;
    iv[d] = 1'b0;
    if (!got) begin
      chk("accept_timeout", 64'd0, 64'd1);
      return;
    end
    got = 0;
    n = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (ov[d]) got = 1;
    end
    chk($sformatf("latency[%0d]", d), 64'(n), 64'(lat(d)));
    first = od[d];
    if (lit >= 0) chk($sformatf("result[%0d] T=%0d", d, t), 64'(od[d]), lit);
    if (d == 2) begin
      q   = modq(d, qh[d]);
      lhs = (128'(od[d]) * 128'(qh[d]) * 128'(qh[d])) % q;
      chk("k2_identity", lhs[63:0], 64'(128'(t) % q));
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 64'(ov[d]), 64'd1);
      chk("hold_data", 64'(od[d]), 64'(first));
      chk("hold_in_ready", 64'(ir[d]), 64'd0);
    end
    @(posedge clk); #1;
    ordy[d] = 1'b1;
    @(posedge clk); #1;
    ordy[d] = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 64'(ir[d]), 64'd1);
    chk("idle_out_valid", 64'(ov[d]), 64'd0);
  endtask

  initial begin
    int  base;
    bit  got;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b0; id[d] = '0; qh[d] = '0;
      busy[d] = 1'b0; acc[d] = 0; ev[d] = '0; nres[d] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 64'(ir[0]), 64'd0);
    chk("reset_out_valid", 64'(ov[0]), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    qh[0] = 15'd13; qh[1] = 15'd13; qh[2] = 15'd16385;
    @(negedge clk);
    chk("post_reset_in_ready", 64'(ir[0]), 64'd1);
    chk("model_pin_1", 64'(model(0, 32'd1, 15'd13)), 64'd2285);
    chk("model_pin_3328", 64'(model(0, 32'd3328, 15'd13)), 64'd1044);

    run(0, 32'd1,    2285, 0);
    run(0, 32'd169,  1,    0);
    run(0, 32'd0,    0,    0);
    run(0, 32'd3328, 1044, 0);
    run(0, 32'd3334, 1438, 0);
    run(0, 32'd5,    1438, 0);

    run(1, 32'd1, 2285, 5);

    // Back-to-back: in_data changes every cycle, only values at accept edges count.
    base = nres[1];
    @(posedge clk); #1;
    ordy[1] = 1'b1;
    iv[1]   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      id[1] = 32'((i * 37 + 3) & 12'hFFF);
      @(posedge clk); #1;
    end
    iv[1] = 1'b0;
    repeat (10) @(posedge clk);
    #1 ordy[1] = 1'b0;
    chk("b2b_result_count", 64'(nres[1] - base), 64'd6);

    // Reset while in RUN discards the transaction.
    base = nres[0];
    @(posedge clk); #1;
    id[0] = 32'd7;
    iv[0] = 1'b1;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (ir[0]) got = 1;
    end
    chk("rst_test_accept", 64'(got), 64'd1);
    @(posedge clk); #1;
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready_low", 64'(ir[0]), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_idle_out_valid", 64'(ov[0]), 64'd0);
    chk("rst_idle_in_ready", 64'(ir[0]), 64'd1);
    repeat (25) @(negedge clk);
    chk("rst_no_result", 64'(nres[0] - base), 64'd0);
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    run(0, 32'd1, 2285, 0);

    for (int i = 0; i < 6; i++) run(2, $urandom, -1, 0);
    run(2, 32'hFFFF_FFFF, -1, 0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/k2_unscale.md
Name: k2_unscale

Overview:
- Converts a value out of the K2-RED scaled domain.
- A K2-RED reduction with q = qH*2^W + 1 returns T ≡ k^2*C mod q, where k = qH.
- This block accepts such a T and returns C mod q = T*k^-2 mod q.
- Since 2^W ≡ -k^-1 (mod q), k^-2 ≡ 2^(2W) mod q. The block computes this with 2W iterated modular doublings under a valid/ready handshake.
- It sits after k2red-based datapaths, at NTT/pointwise-multiply output boundaries, to remove the accumulated k^2 factor.

Parameters:
- LOGQ, 32, modulus width in bits; q < 2^LOGQ.
- LOGQH, 15, width of qH; W = LOGQ - LOGQH.
- STEPS, 1, modular doublings per clock in RUN; must divide 2W (elaboration error otherwise).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- qH  input  LOGQH  modulus high part; q = {qH, (W-1)'b0, 1'b1}; qH[LOGQH-1] must be 1. Sampled only at accept.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept; high only in IDLE and when rst=0.
- in_data  input  LOGQ  scaled value T, any value in [0, 2^LOGQ), which is below 2q.
- out_valid  output  1  out_data valid; held until out_ready.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  LOGQ  T*2^(2W) mod q, fully reduced to [0, q).

Behaviour:
- State register values: IDLE, PRE, RUN, DONE.
- Internal registers:
  - x: LOGQ+1 bits.
  - q_r: latched q.
  - cnt: counts doublings, 0..2W.
- Reset (rst=1 at a rising edge):
  - state=IDLE, x=0, cnt=0, out_valid=0, out_data=0.
  - in_ready=0 while rst is high.
  - A transaction in flight is discarded and no output is produced for it.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready: x<=in_data, q_r<=q from current qH, cnt<=0, go to PRE.
- PRE (1 cycle): if x >= q_r then x <= x - q_r; go to RUN. Afterwards x < q_r.
- RUN:
  - Each cycle applies STEPS sequential steps, each y = 2x; if y >= q_r then y -= q_r.
  - cnt <= cnt + STEPS.
  - When the updated cnt equals 2W, go to DONE.
  - x stays < q_r after every step; LOGQ+1 bits suffice for 2x.
- DONE:
  - out_valid=1, out_data=x[LOGQ-1:0].
  - On out_ready, go to IDLE; out_valid drops the following cycle.
  - While out_ready=0, out_data and out_valid stay stable.
- Latency: with accept in cycle 0, out_valid first goes high in cycle 2 + 2W/STEPS. There is no overlap: the next accept is possible at the earliest one cycle after the output handshake.
- in_ready is a pure function of state and rst (no combinational path from out_ready).
- Changes to in_valid, in_data or qH while busy are ignored.
- out_data value in non-DONE states: holds the last result, or 0 after reset. It is not checked by the bench.

Test Plan:
- Kyber q (LOGQ=12, LOGQH=4, qH=13, q=3329, W=8, STEPS=1), in_data=1 -> out_data=2285 (2^16 mod 3329); out_valid first high in cycle 18 after accept.
- Same config, in_data=169 (k^2) -> 1; in_data=0 -> 0; in_data=3328 -> 1044.
- Pre-reduction: in_data=3334 (>=q) -> 1438, identical to the result for in_data=5.
- STEPS=4, in_data=1 -> 2285 with out_valid in cycle 6. Then hold out_ready=0 for 5 cycles -> out_valid and out_data stable, in_ready=0 throughout; raise out_ready -> IDLE next cycle, in_ready=1.
- Back-to-back with in_valid held high and in_data changing while busy -> only values present at in_ready=1 edges are processed, results in order.
- Assert rst during RUN -> the next cycle is IDLE with out_valid=0, and no result is produced. A new accept of in_data=1 then yields 2285 with normal latency.
- Default params (LOGQ=32, LOGQH=15, qH=16385, W=17), random in_data -> matches the reference model (T*2^34) mod q; also check (out_data*qH^2) mod q == in_data mod q.
